load_store_unit: RTL

//  Parametrised multi-cycle load/store unit between the datapath and a handshaked data memory.

---
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: byte/half/word/dword accesses with alignment and size
// checking, lane steering, sign/zero extension and a bus wait-state timeout.
module load_store_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [1:0]          resp_err,
  output logic                busy
);

  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);
  localparam bit TMO_EN = (TIMEOUT_CYC != 0);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_SIZE  = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  state_t          state;
  logic [7:0]      tmo_cnt;
  logic [LW-1:0]   lane_reg;
  logic [1:0]      size_reg;
  logic            uns_reg;

  function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] size);
    logic [DATA_W-1:0] m;
    m = '0;
    case (size)
      2'b00:   m[7:0]  = '1;
      2'b01:   m[15:0] = '1;
      2'b10:   m[31:0] = '1;
      default: m       = '1;
    endcase
    return m;
  endfunction

  logic [LW-1:0]     req_lane;
  logic              size_illegal;
  logic              misaligned;
  logic [NB-1:0]     store_be;
  logic [DATA_W-1:0] store_wdata;

  assign req_lane     = req_addr[LW-1:0];
  assign size_illegal = (req_size == 2'b11) && (DATA_W == 32);

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  // A lane is enabled when it falls inside [lane, lane + 2^size).
  for (genvar gi = 0; gi < NB; gi++) begin : g_be
    assign store_be[gi] = (gi >= int'(req_lane)) && (gi < int'(req_lane) + (1 << req_size));
  end

  assign store_wdata = (req_wdata & size_mask(req_size)) << {req_lane, 3'b000};

  logic [DATA_W-1:0] load_shifted;
  logic [DATA_W-1:0] load_mask;
  logic              load_sign;
  logic [DATA_W-1:0] load_data;

  assign load_shifted = mem_rdata >> {lane_reg, 3'b000};
  assign load_mask    = size_mask(size_reg);

  always_comb begin
    load_sign = 1'b0;
    case (size_reg)
      2'b00:   load_sign = load_shifted[7];
      2'b01:   load_sign = load_shifted[15];
      2'b10:   load_sign = load_shifted[31];
      default: load_sign = load_shifted[DATA_W-1];
    endcase
  end

  assign load_data = (load_shifted & load_mask) | ((load_sign && !uns_reg) ? ~load_mask : '0);

  assign busy      = (state != IDLE);
  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      lane_reg   <= '0;
      size_reg   <= '0;
      uns_reg    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lane_reg <= req_lane;
            size_reg <= req_size;
            uns_reg  <= req_unsigned;
            tmo_cnt  <= '0;
            if (size_illegal) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= ERR_SIZE;
              resp_rdata <= '0;
            end else if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= ERR_ALIGN;
              resp_rdata <= '0;
            end else begin
              state     <= BUS;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_W-1:LW], {LW{1'b0}}};
              mem_be    <= req_we ? store_be : '1;
              mem_wdata <= req_we ? store_wdata : '0;
            end
          end
        end
        BUS: begin
          // An ack in the final allowed cycle takes priority over the timeout.
          if (mem_ack) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            resp_valid <= 1'b1;
            resp_err   <= ERR_OK;
            resp_rdata <= mem_we ? '0 : load_data;
          end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            resp_valid <= 1'b1;
            resp_err   <= ERR_TMO;
            resp_rdata <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_err   <= ERR_OK;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
